dummy_accelerator_issue: RTL and testbench

DUMMY_ACCELERATOR_ISSUE -- requirements
Module: dummy_accelerator_issue

---
 rtl/dummy_accelerator_pkg.sv | 35 +++
 rtl/dummy_accelerator_decoder.sv | 25 ++
 rtl/dummy_accelerator_issue.sv | 121 ++++++++++++
 tb/tb_dummy_accelerator_issue.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/dummy_accelerator_pkg.sv
// Shared types, widths and decode constants for the dummy X-IF accelerator.
package dummy_accelerator_pkg;

    localparam int XLEN          = 32;
    localparam int X_NUM_RS      = 2;
    localparam int X_ID_WIDTH    = 4;
    localparam int IMM_WIDTH     = 12;
    localparam int DEFAULT_DEPTH = 4;

    // opcode[6:0] and funct3[14:12] are the only decoded fields
    localparam logic [31:0] DUMMY_MASK            = 32'h0000_707F;
    localparam logic [31:0] DUMMY_ITERATIVE_MATCH = 32'h0000_0077;
    localparam logic [31:0] DUMMY_PIPELINE_MATCH  = 32'h0000_005B;

    typedef enum logic {
        EU_CTL_PIPELINE  = 1'b0,
        EU_CTL_ITERATIVE = 1'b1
    } ctl_type_t;

    typedef struct packed {
        logic [X_ID_WIDTH-1:0] id;
        logic [4:0]            rd_idx;
    } TagType_t;

    typedef struct packed {
        ctl_type_t             ctl;
        logic [IMM_WIDTH-1:0]  imm;
        logic [XLEN-1:0]       rs1;
        logic [XLEN-1:0]       rs2;
        TagType_t              tag;
        logic                  committed;
        logic                  killed;
    } DummyIssueEntry_t;

endpackage

// File: rtl/dummy_accelerator_decoder.sv
// Combinational decode of the two dummy custom instructions.
module dummy_accelerator_decoder
    import dummy_accelerator_pkg::*;
(
    input  logic [31:0]          instr,
    output logic                 match,
    output ctl_type_t            ctl,
    output logic [IMM_WIDTH-1:0] imm,
    output logic [4:0]           rd
);

    logic [31:0] masked;
    logic        is_iterative;
    logic        is_pipeline;

    assign masked       = instr & DUMMY_MASK;
    assign is_iterative = (masked == DUMMY_ITERATIVE_MATCH);
    assign is_pipeline  = (masked == DUMMY_PIPELINE_MATCH);

    assign match = is_iterative | is_pipeline;
    assign ctl   = is_iterative ? EU_CTL_ITERATIVE : EU_CTL_PIPELINE;
    assign imm   = instr[31:20];
    assign rd    = instr[11:7];

endmodule

// File: rtl/dummy_accelerator_issue.sv
// X-IF issue buffer: accepts decoded offloads, waits for commit, dispatches in order.
// Issue response is combinational; eu_valid_o is registered, one cycle after issue+commit.
module dummy_accelerator_issue
    import dummy_accelerator_pkg::*;
#(
    parameter int DEPTH = DEFAULT_DEPTH
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     issue_valid_i,
    output logic                     issue_ready_o,
    input  logic [31:0]              issue_instr_i,
    input  logic [X_ID_WIDTH-1:0]    issue_id_i,
    input  logic [X_NUM_RS*XLEN-1:0] issue_rs_i,
    input  logic [X_NUM_RS-1:0]      issue_rs_valid_i,
    output logic                     issue_accept_o,
    output logic                     issue_writeback_o,
    input  logic                     commit_valid_i,
    input  logic [X_ID_WIDTH-1:0]    commit_id_i,
    input  logic                     commit_kill_i,
    output logic                     eu_valid_o,
    input  logic                     eu_ready_i,
    output ctl_type_t                eu_ctl_o,
    output logic [IMM_WIDTH-1:0]     eu_imm_o,
    output logic [XLEN-1:0]          eu_rs1_o,
    output logic [XLEN-1:0]          eu_rs2_o,
    output TagType_t                 eu_tag_o
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    DummyIssueEntry_t entries      [DEPTH];
    DummyIssueEntry_t entries_next [DEPTH];
    DummyIssueEntry_t new_entry;
    logic [DEPTH-1:0] valid, valid_next;
    logic [PW-1:0]    head, head_next, tail, tail_next;
    logic [CW-1:0]    count, count_next;
    logic             eu_valid, eu_valid_next;

    logic                 dec_match;
    ctl_type_t            dec_ctl;
    logic [IMM_WIDTH-1:0] dec_imm;
    logic [4:0]           dec_rd;
    logic                 full, push, pop, commit_hits_new;

    dummy_accelerator_decoder u_decoder (
        .instr (issue_instr_i),
        .match (dec_match),
        .ctl   (dec_ctl),
        .imm   (dec_imm),
        .rd    (dec_rd)
    );

    // A full buffer blocks even when the head pops this cycle: no bypass path.
    assign full              = (count == CW'(DEPTH));
    assign issue_ready_o     = !dec_match || ((&issue_rs_valid_i) && !full);
    assign push              = issue_valid_i && dec_match && (&issue_rs_valid_i) && !full;
    assign issue_accept_o    = push;
    assign issue_writeback_o = push;

    assign pop             = (eu_valid && eu_ready_i) || (valid[head] && entries[head].killed);
    assign commit_hits_new = commit_valid_i && (commit_id_i == issue_id_i);

    always_comb begin
        new_entry           = '0;
        new_entry.ctl       = dec_ctl;
        new_entry.imm       = dec_imm;
        new_entry.rs1       = issue_rs_i[XLEN-1:0];
        new_entry.rs2       = issue_rs_i[2*XLEN-1:XLEN];
        new_entry.tag.id    = issue_id_i;
        new_entry.tag.rd_idx = dec_rd;
        new_entry.committed = commit_hits_new && !commit_kill_i;
        new_entry.killed    = commit_hits_new && commit_kill_i;

        entries_next = entries;
        valid_next   = valid;
        for (int i = 0; i < DEPTH; i++) begin
            if (commit_valid_i && valid[i] && (entries[i].tag.id == commit_id_i)) begin
                if (commit_kill_i) entries_next[i].killed    = 1'b1;
                else               entries_next[i].committed = 1'b1;
            end
        end
        if (pop) valid_next[head] = 1'b0;
        if (push) begin
            entries_next[tail] = new_entry;
            valid_next[tail]   = 1'b1;
        end

        head_next  = head + PW'(pop);
        tail_next  = tail + PW'(push);
        count_next = count + CW'(push) - CW'(pop);
        eu_valid_next = valid_next[head_next] && entries_next[head_next].committed
                        && !entries_next[head_next].killed;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            valid    <= '0;
            head     <= '0;
            tail     <= '0;
            count    <= '0;
            eu_valid <= 1'b0;
        end else begin
            entries  <= entries_next;
            valid    <= valid_next;
            head     <= head_next;
            tail     <= tail_next;
            count    <= count_next;
            eu_valid <= eu_valid_next;
        end
    end

    assign eu_valid_o = eu_valid;
    assign eu_ctl_o   = entries[head].ctl;
    assign eu_imm_o   = entries[head].imm;
    assign eu_rs1_o   = entries[head].rs1;
    assign eu_rs2_o   = entries[head].rs2;
    assign eu_tag_o   = entries[head].tag;

endmodule

// File: tb/tb_dummy_accelerator_issue.sv
// Directed bench: issue responses checked inline, dispatches checked by a scoreboard monitor.
module tb_dummy_accelerator_issue;
    import dummy_accelerator_pkg::*;

    logic                     clk_i = 1'b0;
    logic                     rst_i;
    logic                     issue_valid_i;
    logic                     issue_ready_o;
    logic [31:0]              issue_instr_i;
    logic [X_ID_WIDTH-1:0]    issue_id_i;
    logic [X_NUM_RS*XLEN-1:0] issue_rs_i;
    logic [X_NUM_RS-1:0]      issue_rs_valid_i;
    logic                     issue_accept_o;
    logic                     issue_writeback_o;
    logic                     commit_valid_i;
    logic [X_ID_WIDTH-1:0]    commit_id_i;
    logic                     commit_kill_i;
    logic                     eu_valid_o;
    logic                     eu_ready_i;
    ctl_type_t                eu_ctl_o;
    logic [IMM_WIDTH-1:0]     eu_imm_o;
    logic [XLEN-1:0]          eu_rs1_o;
    logic [XLEN-1:0]          eu_rs2_o;
    TagType_t                 eu_tag_o;

    always #5 clk_i = ~clk_i;

    dummy_accelerator_issue #(.DEPTH(4)) dut (
        .clk_i             (clk_i),
        .rst_i             (rst_i),
        .issue_valid_i     (issue_valid_i),
        .issue_ready_o     (issue_ready_o),
        .issue_instr_i     (issue_instr_i),
        .issue_id_i        (issue_id_i),
        .issue_rs_i        (issue_rs_i),
        .issue_rs_valid_i  (issue_rs_valid_i),
        .issue_accept_o    (issue_accept_o),
        .issue_writeback_o (issue_writeback_o),
        .commit_valid_i    (commit_valid_i),
        .commit_id_i       (commit_id_i),
        .commit_kill_i     (commit_kill_i),
        .eu_valid_o        (eu_valid_o),
        .eu_ready_i        (eu_ready_i),
        .eu_ctl_o          (eu_ctl_o),
        .eu_imm_o          (eu_imm_o),
        .eu_rs1_o          (eu_rs1_o),
        .eu_rs2_o          (eu_rs2_o),
        .eu_tag_o          (eu_tag_o)
    );

    typedef struct packed {
        logic        ctl;
        logic [11:0] imm;
        logic [31:0] rs1;
        logic [31:0] rs2;
        logic [3:0]  id;
        logic [4:0]  rd;
    } exp_t;

    localparam logic [31:0] I_ITER  = 32'h00A0_81F7; // imm 0x00A, rd 3
    localparam logic [31:0] I_PIPE  = 32'h0050_82DB; // imm 0x005, rd 5
    localparam logic [31:0] I_ADD   = 32'h0000_0033;
    localparam logic [31:0] I_F3BAD = 32'h00A0_91F7; // iterative opcode, funct3=001

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    task automatic check(input string name, input logic [95:0] act, input logic [95:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
        end
    endtask

    function automatic exp_t mk(input logic ctl, input logic [11:0] imm, input logic [31:0] rs1,
                                input logic [31:0] rs2, input logic [3:0] id, input logic [4:0] rd);
        exp_t e;
        e = '{ctl: ctl, imm: imm, rs1: rs1, rs2: rs2, id: id, rd: rd};
        return e;
    endfunction

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic do_issue(input logic [31:0] instr, input logic [3:0] id, input logic [31:0] rs1,
                            input logic [31:0] rs2, input logic [1:0] rsv, input logic commit,
                            input logic exp_rdy, input logic exp_acc);
        issue_valid_i    = 1'b1;
        issue_instr_i    = instr;
        issue_id_i       = id;
        issue_rs_i       = {rs2, rs1};
        issue_rs_valid_i = rsv;
        commit_valid_i   = commit;
        commit_id_i      = id;
        commit_kill_i    = 1'b0;
        #2;
        check("issue_ready", 96'(issue_ready_o), 96'(exp_rdy));
        check("issue_accept", 96'(issue_accept_o), 96'(exp_acc));
        check("issue_writeback", 96'(issue_writeback_o), 96'(exp_acc));
        tick();
        issue_valid_i  = 1'b0;
        commit_valid_i = 1'b0;
    endtask

    task automatic do_commit(input logic [3:0] id, input logic kill);
        commit_valid_i = 1'b1;
        commit_id_i    = id;
        commit_kill_i  = kill;
        tick();
        commit_valid_i = 1'b0;
        commit_kill_i  = 1'b0;
    endtask

    always @(negedge clk_i) begin : monitor
        exp_t got;
        exp_t e;
        if (!rst_i && eu_valid_o && eu_ready_i) begin
            got = {eu_ctl_o == EU_CTL_ITERATIVE, eu_imm_o, eu_rs1_o, eu_rs2_o, eu_tag_o};
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_dispatch: got id %0d, required no dispatch", eu_tag_o.id);
            end else begin
                e = exp_q.pop_front();
                check("dispatch", 96'(got), 96'(e));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst_i = 1'b1; issue_valid_i = 1'b0; issue_instr_i = '0; issue_id_i = '0;
        issue_rs_i = '0; issue_rs_valid_i = '0; commit_valid_i = 1'b0; commit_id_i = '0;
        commit_kill_i = 1'b0; eu_ready_i = 1'b1;
        tick(); tick();
        check("reset_eu_valid", 96'(eu_valid_o), 96'(0));
        rst_i = 1'b0;
        #1;
        check("idle_ready", 96'(issue_ready_o), 96'(1));
        check("idle_accept", 96'(issue_accept_o), 96'(0));

        // Issue + commit same cycle: dispatch on the very next cycle.
        exp_q.push_back(mk(1'b1, 12'h00A, 32'h11, 32'h22, 4'd2, 5'd3));
        do_issue(I_ITER, 4'd2, 32'h11, 32'h22, 2'b11, 1'b1, 1'b1, 1'b1);
        check("latency_eu_valid", 96'(eu_valid_o), 96'(1));
        tick();
        check("drained_eu_valid", 96'(eu_valid_o), 96'(0));

        // Delayed commit: no dispatch until one cycle after the commit.
        do_issue(I_PIPE, 4'd1, 32'h33, 32'h44, 2'b11, 1'b0, 1'b1, 1'b1);
        for (int i = 0; i < 5; i++) begin
            check("wait_commit_eu_valid", 96'(eu_valid_o), 96'(0));
            tick();
        end
        exp_q.push_back(mk(1'b0, 12'h005, 32'h33, 32'h44, 4'd1, 5'd5));
        do_commit(4'd1, 1'b0);
        check("post_commit_eu_valid", 96'(eu_valid_o), 96'(1));
        tick();

        // Non-matching and operand-not-ready issues.
        do_issue(I_ADD, 4'd3, 32'h0, 32'h0, 2'b11, 1'b0, 1'b1, 1'b0);
        do_issue(I_F3BAD, 4'd3, 32'h0, 32'h0, 2'b11, 1'b0, 1'b1, 1'b0);
        do_issue(I_ITER, 4'd3, 32'h0, 32'h0, 2'b01, 1'b0, 1'b0, 1'b0);
        do_issue(I_PIPE, 4'd3, 32'h0, 32'h0, 2'b10, 1'b0, 1'b0, 1'b0);
        check("no_enqueue_eu_valid", 96'(eu_valid_o), 96'(0));

        // Fill the buffer with the execution unit stalled.
        eu_ready_i = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (i % 2 == 0) begin
                exp_q.push_back(mk(1'b1, 12'h00A, 32'h100 + i, 32'h200 + i, 4'(i), 5'd3));
                do_issue(I_ITER, 4'(i), 32'h100 + i, 32'h200 + i, 2'b11, 1'b1, 1'b1, 1'b1);
            end else begin
                exp_q.push_back(mk(1'b0, 12'h005, 32'h100 + i, 32'h200 + i, 4'(i), 5'd5));
                do_issue(I_PIPE, 4'(i), 32'h100 + i, 32'h200 + i, 2'b11, 1'b1, 1'b1, 1'b1);
            end
        end
        check("stall_eu_valid", 96'(eu_valid_o), 96'(1));
        do_issue(I_ITER, 4'd7, 32'h0, 32'h0, 2'b11, 1'b0, 1'b0, 1'b0);
        check("stall_hold_id", 96'(eu_tag_o.id), 96'(0));
        check("stall_hold_rs1", 96'(eu_rs1_o), 96'(32'h100));
        // Full while the head pops: still not ready.
        eu_ready_i = 1'b1;
        do_issue(I_PIPE, 4'd8, 32'h0, 32'h0, 2'b11, 1'b0, 1'b0, 1'b0);
        for (int i = 1; i < 4; i++) begin
            check("drain_eu_valid", 96'(eu_valid_o), 96'(1));
            check("drain_id", 96'(eu_tag_o.id), 96'(i));
            tick();
        end
        check("drained_all_eu_valid", 96'(eu_valid_o), 96'(0));

        // Killed entry in the middle is skipped.
        do_issue(I_ITER, 4'd4, 32'h44, 32'h54, 2'b11, 1'b0, 1'b1, 1'b1);
        do_issue(I_PIPE, 4'd5, 32'h45, 32'h55, 2'b11, 1'b0, 1'b1, 1'b1);
        do_issue(I_PIPE, 4'd6, 32'h46, 32'h56, 2'b11, 1'b0, 1'b1, 1'b1);
        do_commit(4'd5, 1'b1);
        exp_q.push_back(mk(1'b1, 12'h00A, 32'h44, 32'h54, 4'd4, 5'd3));
        do_commit(4'd4, 1'b0);
        exp_q.push_back(mk(1'b0, 12'h005, 32'h46, 32'h56, 4'd6, 5'd5));
        do_commit(4'd6, 1'b0);
        repeat (4) tick();
        check("kill_queue_empty", 96'(exp_q.size()), 96'(0));

        // Reset discards buffered entries; old ids must not dispatch afterwards.
        eu_ready_i = 1'b0;
        do_issue(I_ITER, 4'd9, 32'h9, 32'h9, 2'b11, 1'b1, 1'b1, 1'b1);
        do_issue(I_PIPE, 4'd10, 32'hA, 32'hA, 2'b11, 1'b0, 1'b1, 1'b1);
        do_issue(I_PIPE, 4'd11, 32'hB, 32'hB, 2'b11, 1'b0, 1'b1, 1'b1);
        check("pre_reset_eu_valid", 96'(eu_valid_o), 96'(1));
        rst_i = 1'b1;
        tick();
        rst_i = 1'b0;
        check("post_reset_eu_valid", 96'(eu_valid_o), 96'(0));
        eu_ready_i = 1'b1;
        do_commit(4'd10, 1'b0);
        do_commit(4'd11, 1'b0);
        repeat (3) tick();
        check("stale_commit_eu_valid", 96'(eu_valid_o), 96'(0));
        exp_q.push_back(mk(1'b1, 12'h00A, 32'hC1, 32'hC2, 4'd12, 5'd3));
        do_issue(I_ITER, 4'd12, 32'hC1, 32'hC2, 2'b11, 1'b1, 1'b1, 1'b1);
        check("post_reset_dispatch_valid", 96'(eu_valid_o), 96'(1));
        repeat (3) tick();
        check("final_queue_empty", 96'(exp_q.size()), 96'(0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
